// File: rtl/rob_gen_pkg.sv
// Shared encodings and defaults for the reorder buffer.
package rob_gen_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_IDX_W = 4;

   typedef enum logic [2:0] {
      TypeS  = 3'd0,
      TypeR  = 3'd1,
      TypeB  = 3'd2,
      TypeJ  = 3'd3,
      TypeJr = 3'd4
   } rob_type_e;

   function automatic logic writes_rd(input logic [2:0] t);
      return (t == TypeR) || (t == TypeJ) || (t == TypeJr);
   endfunction

endpackage

// File: rtl/rob_gen_wb_fwd.sv
// Operand lookup: stored result first, otherwise the lowest writeback channel hitting the id.
module rob_wb_fwd #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned WB_CH = 2
) (
   input  logic [IDX_W-1:0]       id_i,
   input  logic                   stored_done_i,
   input  logic [31:0]            stored_val_i,
   input  logic [WB_CH-1:0]       wb_valid_i,
   input  logic [WB_CH*IDX_W-1:0] wb_rob_id_i,
   input  logic [WB_CH*32-1:0]    wb_val_i,
   output logic                   avail_o,
   output logic [31:0]            val_o
);

   logic        hit;
   logic [31:0] fwd_val;

   always_comb begin
      hit     = 1'b0;
      fwd_val = 32'h0;
      // Walk downwards so the lowest matching channel is the last to assign.
      for (int c = WB_CH - 1; c >= 0; c--) begin
         if (wb_valid_i[c] && (wb_rob_id_i[c*IDX_W +: IDX_W] == id_i)) begin
            hit     = 1'b1;
            fwd_val = wb_val_i[c*32 +: 32];
         end
      end
      avail_o = stored_done_i;
      val_o   = stored_val_i;
      if (!stored_done_i && hit) begin
         avail_o = 1'b1;
         val_o   = fwd_val;
      end
   end

endmodule

// File: rtl/rob_gen.sv
// Reorder buffer: in-order issue/commit, out-of-order writeback, mispredict flush.
module rob_gen
   import rob_gen_pkg::*;
#(
   parameter int unsigned DEPTH      = ROB_DEPTH,
   parameter int unsigned IDX_W      = ROB_IDX_W,
   parameter int unsigned WB_CH      = 2,
   parameter int unsigned FULL_SLACK = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   is_ins,
   input  logic [2:0]             ins_type,
   input  logic [4:0]             ins_rd,
   input  logic [31:0]            ins_pc,
   input  logic                   ins_pred_jmp,
   input  logic [31:0]            ins_pred_tgt,
   input  logic [31:0]            ins_alt_pc,
   output logic [IDX_W-1:0]       rob_free_id,
   output logic [IDX_W-1:0]       rob_head_id,
   output logic                   rob_full,
   output logic                   rob_empty,
   output logic [IDX_W:0]         rob_count,
   input  logic [WB_CH-1:0]       wb_valid,
   input  logic [WB_CH*IDX_W-1:0] wb_rob_id,
   input  logic [WB_CH*32-1:0]    wb_val,
   input  logic [WB_CH*32-1:0]    wb_tgt,
   output logic                   is_commit,
   output logic [4:0]             set_id,
   output logic [31:0]            set_val,
   output logic [IDX_W-1:0]       set_from_rob_id,
   output logic [4:0]             set_dep_id,
   output logic [IDX_W-1:0]       set_dep_Q,
   input  logic [IDX_W-1:0]       get_rob_id_1,
   input  logic [IDX_W-1:0]       get_rob_id_2,
   output logic                   rob_avail_1,
   output logic                   rob_avail_2,
   output logic [31:0]            rob_val_1,
   output logic [31:0]            rob_val_2,
   output logic                   is_b_res,
   output logic [7:0]             b_res_pc_part,
   output logic                   b_res_jmp,
   output logic                   rob_clear,
   output logic [31:0]            new_pc
);

   localparam int unsigned CW = IDX_W + 1;

   logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d;
   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             clear_q, clear_d;
   logic [31:0]      new_pc_q, new_pc_d;

   // Payload; validity is tracked by busy/done so no reset is needed.
   logic [2:0]  type_q     [DEPTH];
   logic [4:0]  rd_q       [DEPTH];
   logic [7:0]  pc_part_q  [DEPTH];
   logic        pred_jmp_q [DEPTH];
   logic [31:0] pred_tgt_q [DEPTH];
   logic [31:0] alt_pc_q   [DEPTH];
   logic [31:0] val_q      [DEPTH];
   logic [31:0] tgt_q      [DEPTH];

   logic       issue, commit, br_miss, jr_miss;
   logic [2:0] head_type;
   logic       unused_pc;

   assign unused_pc = ^{ins_pc[31:9], ins_pc[0]};

   assign head_type = type_q[head_q];
   assign issue     = is_ins && rdy_in && !clear_q;
   assign commit    = rdy_in && !clear_q && busy_q[head_q] && done_q[head_q];
   assign br_miss   = (head_type == TypeB) && (val_q[head_q][0] != pred_jmp_q[head_q]);
   assign jr_miss   = (head_type == TypeJr) && (tgt_q[head_q] != pred_tgt_q[head_q]);

   always_comb begin
      busy_d   = busy_q;
      done_d   = done_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      clear_d  = clear_q;
      new_pc_d = new_pc_q;
      if (rdy_in) begin
         if (clear_q) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            clear_d = 1'b0;
         end else begin
            for (int c = 0; c < WB_CH; c++) begin
               if (wb_valid[c] && busy_q[wb_rob_id[c*IDX_W +: IDX_W]]) begin
                  done_d[wb_rob_id[c*IDX_W +: IDX_W]] = 1'b1;
               end
            end
            if (commit) begin
               busy_d[head_q] = 1'b0;
               done_d[head_q] = 1'b0;
               head_d         = head_q + 1'b1;
               if (br_miss || jr_miss) begin
                  clear_d  = 1'b1;
                  new_pc_d = br_miss ? alt_pc_q[head_q] : tgt_q[head_q];
               end
            end
            if (issue) begin
               busy_d[tail_q] = 1'b1;
               done_d[tail_q] = 1'b0;
               tail_d         = tail_q + 1'b1;
            end
            count_d = count_q + CW'(issue) - CW'(commit);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q   <= '0;
         done_q   <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         clear_q  <= 1'b0;
         new_pc_q <= 32'h0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         clear_q  <= clear_d;
         new_pc_q <= new_pc_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (issue) begin
         type_q[tail_q]     <= ins_type;
         rd_q[tail_q]       <= ins_rd;
         pc_part_q[tail_q]  <= ins_pc[8:1];
         pred_jmp_q[tail_q] <= ins_pred_jmp;
         pred_tgt_q[tail_q] <= ins_pred_tgt;
         alt_pc_q[tail_q]   <= ins_alt_pc;
      end
      if (rdy_in && !clear_q) begin
         for (int c = 0; c < WB_CH; c++) begin
            if (wb_valid[c] && busy_q[wb_rob_id[c*IDX_W +: IDX_W]]) begin
               val_q[wb_rob_id[c*IDX_W +: IDX_W]] <= wb_val[c*32 +: 32];
               tgt_q[wb_rob_id[c*IDX_W +: IDX_W]] <= wb_tgt[c*32 +: 32];
            end
         end
      end
   end

   rob_wb_fwd #(
      .IDX_W(IDX_W),
      .WB_CH(WB_CH)
   ) u_fwd_1 (
      .id_i         (get_rob_id_1),
      .stored_done_i(done_q[get_rob_id_1]),
      .stored_val_i (val_q[get_rob_id_1]),
      .wb_valid_i   (wb_valid),
      .wb_rob_id_i  (wb_rob_id),
      .wb_val_i     (wb_val),
      .avail_o      (rob_avail_1),
      .val_o        (rob_val_1)
   );

   rob_wb_fwd #(
      .IDX_W(IDX_W),
      .WB_CH(WB_CH)
   ) u_fwd_2 (
      .id_i         (get_rob_id_2),
      .stored_done_i(done_q[get_rob_id_2]),
      .stored_val_i (val_q[get_rob_id_2]),
      .wb_valid_i   (wb_valid),
      .wb_rob_id_i  (wb_rob_id),
      .wb_val_i     (wb_val),
      .avail_o      (rob_avail_2),
      .val_o        (rob_val_2)
   );

   assign rob_free_id     = tail_q;
   assign rob_head_id     = head_q;
   assign rob_count       = count_q;
   assign rob_empty       = (count_q == '0);
   assign rob_full        = (count_q >= CW'(DEPTH - FULL_SLACK));
   assign is_commit       = commit;
   assign set_id          = writes_rd(head_type) ? rd_q[head_q] : 5'd0;
   assign set_val         = val_q[head_q];
   assign set_from_rob_id = head_q;
   assign set_dep_id      = (issue && writes_rd(ins_type)) ? ins_rd : 5'd0;
   assign set_dep_Q       = tail_q;
   assign is_b_res        = busy_q[head_q] && done_q[head_q] && (head_type == TypeB);
   assign b_res_pc_part   = pc_part_q[head_q];
   assign b_res_jmp       = val_q[head_q][0];
   assign rob_clear       = clear_q;
   assign new_pc          = new_pc_q;

`ifndef SYNTHESIS
   issue_when_full_a: assert property (@(posedge clk_in) disable iff (!rst_in)
      (is_ins && rdy_in && !clear_q) |-> (count_q != CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_rob_gen.sv
// Directed bench for rob_gen: fill, ordering, forwarding, mispredict flush, async reset.
module tb_rob_gen;
   import rob_gen_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, is_ins, ins_pred_jmp;
   logic [2:0]  ins_type;
   logic [4:0]  ins_rd;
   logic [31:0] ins_pc, ins_pred_tgt, ins_alt_pc;
   logic [3:0]  rob_free_id, rob_head_id, set_from_rob_id, set_dep_Q;
   logic [3:0]  get_rob_id_1, get_rob_id_2;
   logic        rob_full, rob_empty, is_commit, rob_avail_1, rob_avail_2;
   logic [4:0]  rob_count, set_id, set_dep_id;
   logic [1:0]  wb_valid;
   logic [7:0]  wb_rob_id;
   logic [63:0] wb_val, wb_tgt;
   logic [31:0] set_val, rob_val_1, rob_val_2, new_pc;
   logic        is_b_res, b_res_jmp, rob_clear;
   logic [7:0]  b_res_pc_part;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk_in = ~clk_in;

   rob_gen dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .is_ins(is_ins), .ins_type(ins_type), .ins_rd(ins_rd), .ins_pc(ins_pc),
      .ins_pred_jmp(ins_pred_jmp), .ins_pred_tgt(ins_pred_tgt), .ins_alt_pc(ins_alt_pc),
      .rob_free_id(rob_free_id), .rob_head_id(rob_head_id), .rob_full(rob_full),
      .rob_empty(rob_empty), .rob_count(rob_count),
      .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val), .wb_tgt(wb_tgt),
      .is_commit(is_commit), .set_id(set_id), .set_val(set_val),
      .set_from_rob_id(set_from_rob_id), .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
      .get_rob_id_1(get_rob_id_1), .get_rob_id_2(get_rob_id_2),
      .rob_avail_1(rob_avail_1), .rob_avail_2(rob_avail_2),
      .rob_val_1(rob_val_1), .rob_val_2(rob_val_2),
      .is_b_res(is_b_res), .b_res_pc_part(b_res_pc_part), .b_res_jmp(b_res_jmp),
      .rob_clear(rob_clear), .new_pc(new_pc)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      #1;
      rst_in = 1'b1;
   endtask

   task automatic drive_ins(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] pc,
                            input logic pj, input logic [31:0] ptgt, input logic [31:0] alt);
      is_ins       = 1'b1;
      ins_type     = t;
      ins_rd       = rd;
      ins_pc       = pc;
      ins_pred_jmp = pj;
      ins_pred_tgt = ptgt;
      ins_alt_pc   = alt;
   endtask

   task automatic issue(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] pc,
                        input logic pj, input logic [31:0] ptgt, input logic [31:0] alt);
      drive_ins(t, rd, pc, pj, ptgt, alt);
      tick();
      is_ins = 1'b0;
   endtask

   task automatic drive_wb(input int ch, input logic [3:0] id, input logic [31:0] v,
                           input logic [31:0] t);
      wb_valid[ch]         = 1'b1;
      wb_rob_id[ch*4 +: 4] = id;
      wb_val[ch*32 +: 32]  = v;
      wb_tgt[ch*32 +: 32]  = t;
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; is_ins = 1'b0; ins_type = 3'd0; ins_rd = 5'd0;
      ins_pc = 32'h0; ins_pred_jmp = 1'b0; ins_pred_tgt = 32'h0; ins_alt_pc = 32'h0;
      wb_valid = '0; wb_rob_id = '0; wb_val = '0; wb_tgt = '0;
      get_rob_id_1 = 4'd0; get_rob_id_2 = 4'd0;
      #3;
      check_eq("rst_empty", rob_empty, 1);
      check_eq("rst_full", rob_full, 0);
      check_eq("rst_count", rob_count, 0);
      check_eq("rst_clear", rob_clear, 0);
      check_eq("rst_new_pc", new_pc, 0);
      check_eq("rst_tail", rob_free_id, 0);
      tick();
      rst_in = 1'b1;

      // Fill without writeback; full threshold is 16-2.
      for (int i = 0; i < 13; i++) issue(TypeR, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0);
      check_eq("fill13_full", rob_full, 0);
      issue(TypeR, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0);
      check_eq("fill14_full", rob_full, 1);
      check_eq("fill14_count", rob_count, 14);
      check_eq("fill14_empty", rob_empty, 0);
      rdy_in = 1'b0;
      issue(TypeR, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0);
      rdy_in = 1'b1;
      check_eq("rdy_low_hold", rob_count, 14);

      // 20 issue/commit pairs: tail and head both wrap to 4.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         issue(TypeR, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
         drive_wb(0, 4'(i), 32'h100 + i, 32'h0);
         tick();
         wb_valid = '0;
         check_eq("pair_commit", is_commit, 1);
         check_eq("pair_val", set_val, 32'h100 + i);
         tick();
      end
      check_eq("wrap_tail", rob_free_id, 4);
      check_eq("wrap_head", rob_head_id, 4);
      check_eq("wrap_empty", rob_empty, 1);

      // Issue in the same cycle as a commit keeps count.
      issue(TypeR, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0);
      drive_wb(0, 4'd4, 32'hA, 32'h0);
      tick();
      wb_valid = '0;
      issue(TypeR, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0);
      check_eq("sim_count", rob_count, 1);
      check_eq("sim_head", rob_head_id, 5);
      check_eq("sim_tail", rob_free_id, 6);

      // Out-of-order completion, in-order commit.
      do_reset();
      drive_ins(TypeR, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      check_eq("dep_id", set_dep_id, 1);
      check_eq("dep_q", set_dep_Q, 0);
      tick();
      issue(TypeR, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0);
      issue(TypeR, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0);
      drive_wb(0, 4'd2, 32'h22, 32'h0);
      tick();
      wb_valid = '0;
      check_eq("ooo_no_commit", is_commit, 0);
      drive_wb(0, 4'd0, 32'h11, 32'h0);
      tick();
      wb_valid = '0;
      check_eq("ooo_c0", is_commit, 1);
      check_eq("ooo_c0_val", set_val, 32'h11);
      check_eq("ooo_c0_rd", set_id, 1);
      check_eq("ooo_c0_from", set_from_rob_id, 0);
      drive_wb(0, 4'd1, 32'h33, 32'h0);
      tick();
      wb_valid = '0;
      check_eq("ooo_c1_val", set_val, 32'h33);
      check_eq("ooo_c1_rd", set_id, 2);
      tick();
      check_eq("ooo_c2", is_commit, 1);
      check_eq("ooo_c2_val", set_val, 32'h22);
      check_eq("ooo_c2_rd", set_id, 3);
      tick();
      check_eq("ooo_empty", rob_empty, 1);

      // Same-cycle forwarding, then stored value beats a channel.
      do_reset();
      for (int i = 0; i < 4; i++) issue(TypeR, 5'd4, 32'h0, 1'b0, 32'h0, 32'h0);
      get_rob_id_1 = 4'd3;
      get_rob_id_2 = 4'd2;
      drive_wb(1, 4'd3, 32'h55, 32'h0);
      #1;
      check_eq("fwd_avail", rob_avail_1, 1);
      check_eq("fwd_val", rob_val_1, 32'h55);
      check_eq("fwd_other", rob_avail_2, 0);
      tick();
      wb_valid = '0;
      drive_wb(0, 4'd3, 32'h99, 32'h0);
      #1;
      check_eq("stored_prio", rob_val_1, 32'h55);
      wb_valid = '0;

      // Branch mispredict flush; issue during flush is dropped.
      do_reset();
      drive_ins(TypeB, 5'd9, 32'h1234, 1'b1, 32'h0, 32'h100);
      #1;
      check_eq("b_no_dep", set_dep_id, 0);
      tick();
      is_ins = 1'b0;
      drive_wb(0, 4'd0, 32'h0, 32'h0);
      tick();
      wb_valid = '0;
      check_eq("b_res", is_b_res, 1);
      check_eq("b_res_jmp", b_res_jmp, 0);
      check_eq("b_res_pc", b_res_pc_part, 8'h1A);
      check_eq("b_commit", is_commit, 1);
      tick();
      check_eq("b_clear", rob_clear, 1);
      check_eq("b_new_pc", new_pc, 32'h100);
      drive_ins(TypeR, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      check_eq("flush_no_commit", is_commit, 0);
      tick();
      is_ins = 1'b0;
      check_eq("flush_done", rob_clear, 0);
      check_eq("flush_count", rob_count, 0);
      check_eq("flush_tail", rob_free_id, 0);

      // Jalr mispredict commits the link value, then flushes.
      issue(TypeJr, 5'd1, 32'h0, 1'b0, 32'h40, 32'h0);
      drive_wb(0, 4'd0, 32'h8, 32'h80);
      tick();
      wb_valid = '0;
      check_eq("jr_commit", is_commit, 1);
      check_eq("jr_rd", set_id, 1);
      check_eq("jr_link", set_val, 32'h8);
      tick();
      check_eq("jr_clear", rob_clear, 1);
      check_eq("jr_new_pc", new_pc, 32'h80);
      tick();
      check_eq("jr_cleared", rob_clear, 0);
      issue(TypeJr, 5'd5, 32'h0, 1'b0, 32'h40, 32'h0);
      drive_wb(1, 4'd0, 32'h14, 32'h40);
      tick();
      wb_valid = '0;
      check_eq("jr_ok_rd", set_id, 5);
      tick();
      check_eq("jr_ok_no_clear", rob_clear, 0);
      check_eq("jr_ok_empty", rob_empty, 1);

      // Async reset in the flush cycle.
      do_reset();
      issue(TypeB, 5'd0, 32'h0, 1'b1, 32'h0, 32'h200);
      issue(TypeR, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0);
      drive_wb(0, 4'd0, 32'h0, 32'h0);
      tick();
      wb_valid = '0;
      tick();
      check_eq("ar_pre_clear", rob_clear, 1);
      rst_in = 1'b0;
      #1;
      check_eq("ar_clear", rob_clear, 0);
      check_eq("ar_count", rob_count, 0);
      check_eq("ar_new_pc", new_pc, 0);
      check_eq("ar_empty", rob_empty, 1);
      rst_in = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
